// File: rtl/puf_response_capture.sv
// puf_response_capture: runs NUM_EVAL clear/launch/sample evaluations of an arbiter-PUF
// and presents a majority-voted response with a per-channel stability mask.
module puf_response_capture #(
    parameter int N_CH       = 32,
    parameter int NUM_EVAL   = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_CH-1:0] arb_in,
    output logic            arb_clr,
    output logic            fire,
    output logic            busy,
    output logic [N_CH-1:0] resp,
    output logic [N_CH-1:0] stable,
    output logic            resp_valid,
    input  logic            resp_ready
);
    localparam int CW = $clog2(NUM_EVAL + 1);
    localparam int SW = $clog2(SETTLE_CYC);

    typedef enum logic [2:0] {IDLE, CLEAR, FIRE, SETTLE, SAMPLE, VOTE, DONE} state_t;

    state_t          state, next;
    logic [N_CH-1:0] sync1, sync2;
    logic [SW-1:0]   settle_cnt;
    logic [CW-1:0]   eval_cnt;
    logic [CW-1:0]   ones [N_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = CLEAR;
            CLEAR:   next = FIRE;
            FIRE:    next = SETTLE;
            SETTLE:  if (settle_cnt == SW'(SETTLE_CYC - 1)) next = SAMPLE;
            SAMPLE:  next = (eval_cnt == CW'(NUM_EVAL - 1)) ? VOTE : CLEAR;
            VOTE:    next = DONE;
            DONE:    if (resp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            settle_cnt <= '0;
            eval_cnt   <= '0;
            arb_clr    <= 1'b0;
            fire       <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp       <= '0;
            stable     <= '0;
            for (int i = 0; i < N_CH; i++) ones[i] <= '0;
        end else begin
            sync1      <= arb_in;
            sync2      <= sync1;
            arb_clr    <= next == CLEAR;
            fire       <= next == FIRE;
            busy       <= next != IDLE;
            resp_valid <= next == DONE;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            if (state == IDLE && start) eval_cnt <= '0;
            else if (state == SAMPLE)   eval_cnt <= eval_cnt + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (state == IDLE && start) ones[i] <= '0;
                else if (state == SAMPLE)   ones[i] <= ones[i] + CW'(sync2[i]);
                if (state == VOTE) begin
                    resp[i]   <= {ones[i], 1'b0} > (CW + 1)'(NUM_EVAL);
                    stable[i] <= ones[i] == '0 || ones[i] == CW'(NUM_EVAL);
                end
            end
        end
    end
endmodule
